// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
// Contents: DivCode encodings, FSM state encoding, 32-bit constants and
// small two's-complement helper functions used at operand capture and at
// result sign correction.
package div_unit_pkg;

    // RV32M division operation select (DivCode).
    typedef enum logic [1:0] {
        DIV_DIV  = 2'b00,
        DIV_DIVU = 2'b01,
        DIV_REM  = 2'b10,
        DIV_REMU = 2'b11
    } div_code_e;

    // Divider FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } div_state_e;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    // Two's-complement negation.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return (~x) + 32'd1;
    endfunction

    // Magnitude of x when interpreted as signed; x unchanged when unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        logic [31:0] r;
        if (is_signed && x[31]) begin
            r = neg32(x);
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_unit_adder.sv
// adder_32bits: shared 32-bit ripple/carry adder of the EX datapath.
// Ports:
//   a_i   [31:0]  first operand
//   b_i   [31:0]  second operand
//   ci_i          carry in
//   sum_o [31:0]  a_i + b_i + ci_i (low 32 bits)
//   co_o          carry out
module adder_32bits (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        ci_i,
    output logic [31:0] sum_o,
    output logic        co_o
);

    logic [32:0] full_s;

    // 33-bit sum so the carry out is available to callers doing compares.
    always_comb begin
        full_s = {1'b0, a_i} + {1'b0, b_i} + {32'd0, ci_i};
    end

    assign sum_o = full_s[31:0];
    assign co_o  = full_s[32];

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; 34 cycles from accepted start to done for a
// normal op, 2 cycles for divide-by-zero and signed overflow.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request new op (accepted only in IDLE, without flush)
//   DivCode [1:0]   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A, B    [31:0]  dividend, divisor (sampled at accept only)
//   flush           synchronous abort, returns to IDLE without done
//   busy            operation in flight (state != IDLE)
//   done            one-cycle pulse, Result valid
//   Result  [31:0]  quotient or remainder, held until next done
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       DivCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             special_q, special_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             is_signed_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH-1:0] trial_s;
    logic             trial_co_s;
    logic             trial_ok_s;

    // Signed variants have DivCode[0] clear.
    assign is_signed_s = ~DivCode[0];

    // Partial remainder shifted left with the next dividend bit.
    assign rem_shift_s = {rem_q, quo_q[WIDTH-1]};

    // rem_shift - divisor via the shared adder (inverted b, carry in set).
    adder_32bits u_trial_sub (
        .a_i   (rem_shift_s[WIDTH-1:0]),
        .b_i   (~div_q),
        .ci_i  (1'b1),
        .sum_o (trial_s),
        .co_o  (trial_co_s)
    );

    // A set bit 32 means rem_shift >= 2^32 > divisor, so the trial is
    // non-negative regardless of the 32-bit carry; otherwise carry = no borrow.
    assign trial_ok_s = rem_shift_s[WIDTH] | trial_co_s;

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        div_d     = div_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        special_d = special_q;
        done_d    = 1'b0;
        result_d  = result_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        code_d  = DivCode;
                        cnt_d   = '0;
                        q_neg_d = is_signed_s & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_d = is_signed_s & A[WIDTH-1];
                        div_d   = mag32(B, is_signed_s);
                        if (B == '0) begin
                            quo_d     = ALL_ONES;
                            rem_d     = A;
                            special_d = 1'b1;
                            state_d   = FINISH;
                        end else if (is_signed_s && (A == INT_MIN) && (B == ALL_ONES)) begin
                            quo_d     = INT_MIN;
                            rem_d     = '0;
                            special_d = 1'b1;
                            state_d   = FINISH;
                        end else begin
                            // Dividend magnitude shifts out of quo as quotient bits shift in.
                            quo_d     = mag32(A, is_signed_s);
                            rem_d     = '0;
                            special_d = 1'b0;
                            state_d   = CALC;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    quo_d = {quo_q[WIDTH-2:0], trial_ok_s};
                    if (trial_ok_s) begin
                        rem_d = trial_s;
                    end else begin
                        rem_d = rem_shift_s[WIDTH-1:0];
                    end
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        state_d = FINISH;
                    end else begin
                        state_d = CALC;
                    end
                end
                FINISH: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    case (code_q)
                        DIV_DIV, DIV_DIVU: begin
                            if (q_neg_q && !special_q) begin
                                result_d = neg32(quo_q);
                            end else begin
                                result_d = quo_q;
                            end
                        end
                        DIV_REM, DIV_REMU: begin
                            if (r_neg_q && !special_q) begin
                                result_d = neg32(rem_q);
                            end else begin
                                result_d = rem_q;
                            end
                        end
                        default: begin
                            result_d = result_q;
                        end
                    endcase
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            code_q    <= 2'b00;
            div_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            special_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            div_q     <= div_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            special_q <= special_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  DivCode;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = 32'd0;

    div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .DivCode (DivCode),
        .A       (A),
        .B       (B),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .Result  (Result)
    );

    always #5 clk = ~clk;

    // Reference behaviour of RV32M division, independent of the RTL algorithm.
    function automatic logic [31:0] model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        logic        is_rem;
        logic        is_uns;
        logic [31:0] r;
        is_rem = c[1];
        is_uns = c[0];
        if (b == 32'd0) begin
            r = is_rem ? a : 32'hFFFF_FFFF;
        end else if (!is_uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = is_rem ? 32'd0 : 32'h8000_0000;
        end else if (is_uns) begin
            r = is_rem ? (a % b) : (a / b);
        end else begin
            r = is_rem ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start cycle (called just after a falling edge); ends at the
    // falling edge after the accepting rising edge, with operands scrambled.
    task automatic launch(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b, input bit push);
        start   = 1'b1;
        DivCode = c;
        A       = a;
        B       = b;
        if (push) exp_q.push_back(model(c, a, b));
        @(negedge clk);
        start   = 1'b0;
        A       = $urandom;
        B       = $urandom;
        DivCode = 2'($urandom_range(0, 3));
    endtask

    // Wait for done; lat0 is the cycle index already reached since accept.
    task automatic wait_done(input string tag, input int lat0, input int exp_lat);
        int          lat      = lat0;
        int          busy_cnt = 0;
        bit          seen     = 1'b0;
        logic [31:0] e;
        while (!seen && lat <= 100) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                @(negedge clk);
                lat++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (seen) begin
                check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
                check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - lat0));
                check({tag, "_result"}, Result, e);
                last_res = e;
            end
        end
    endtask

    task automatic run(input string tag, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        int exp_lat;
        exp_lat = ((b == 32'd0) || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 34;
        launch(c, a, b, 1'b1);
        wait_done(tag, 1, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        DivCode = 2'b00; A = 32'd0; B = 32'd0;

        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", Result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First op done-pulse shape checked explicitly.
        launch(DIV_DIVU, 32'd100, 32'd7, 1'b1);
        wait_done("divu_100_7", 1, 34);
        @(negedge clk);
        check("done_pulse_low", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);

        run("remu_100_7", DIV_REMU, 32'd100, 32'd7);
        run("div_m7_2", DIV_DIV, 32'hFFFF_FFF9, 32'd2);
        run("rem_m7_2", DIV_REM, 32'hFFFF_FFF9, 32'd2);
        run("div_7_m2", DIV_DIV, 32'd7, 32'hFFFF_FFFE);
        run("rem_7_m2", DIV_REM, 32'd7, 32'hFFFF_FFFE);
        run("divu_5_0", DIV_DIVU, 32'd5, 32'd0);
        run("rem_5_0", DIV_REM, 32'd5, 32'd0);
        run("div_m5_0", DIV_DIV, 32'hFFFF_FFFB, 32'd0);
        run("div_ovf", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run("rem_ovf", DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run("divu_min_ones", DIV_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        run("remu_big", DIV_REMU, 32'hFFFF_FFFF, 32'h0000_0010);
        run("divu_big", DIV_DIVU, 32'hDEAD_BEEF, 32'h0000_1234);
        run("div_min_3", DIV_DIV, 32'h8000_0000, 32'd3);
        run("rem_min_3", DIV_REM, 32'h8000_0000, 32'd3);

        // Result held while idle.
        repeat (5) @(negedge clk);
        check("result_held", Result, last_res);

        // flush mid-operation: no done, Result unchanged.
        launch(DIV_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("flush_no_done", 32'(dones), 32'd0);
        check("flush_result_kept", Result, last_res);

        // flush and start together: start dropped.
        start = 1'b1; flush = 1'b1; DivCode = DIV_DIVU; A = 32'd9; B = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);

        // start while busy ignored; new start in the done cycle accepted.
        launch(DIV_DIVU, 32'd100, 32'd7, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; DivCode = DIV_DIVU; A = 32'd9; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start_ignored", 6, 34);
        launch(DIV_DIVU, 32'd9, 32'd3, 1'b1);
        wait_done("b2b_divu_9_3", 1, 34);
        @(negedge clk);

        // Asynchronous reset mid-operation.
        launch(DIV_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", Result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("arst_no_done", 32'(dones), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);

        run("post_rst_rem", DIV_REM, 32'hFFFF_FF9C, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
